// File: rtl/exception_entry.sv
// Exception-entry sequencer: arbitrates pending exceptions and drives the banked
// register file through SAVE (CPSR/SPSR), LR (r14) and VEC (PC) cycles.
module exception_entry #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] VBASE  = 32'h0000_0000,
  parameter logic [31:0] HVBASE = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_reset,
  input  logic              exc_undef,
  input  logic              exc_svc,
  input  logic              exc_pabt,
  input  logic              exc_dabt,
  input  logic              irq,
  input  logic              fiq,
  input  logic              core_idle,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic [DATA_W-1:0] cpsr_in,
  input  logic              hivecs,
  output logic [4:0]        m_out,
  output logic              write_reg,
  output logic [3:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              write_pc,
  output logic [DATA_W-1:0] pc_data,
  output logic              cpsr_we,
  output logic [DATA_W-1:0] cpsr_out,
  output logic              spsr_we,
  output logic [DATA_W-1:0] spsr_data,
  output logic [4:0]        spsr_mode,
  output logic              busy,
  output logic              done,
  output logic [6:0]        exc_ack
);

  localparam int B_RESET = 0;
  localparam int B_UNDEF = 1;
  localparam int B_SVC   = 2;
  localparam int B_PABT  = 3;
  localparam int B_DABT  = 4;
  localparam int B_IRQ   = 5;
  localparam int B_FIQ   = 6;

  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_FIQ = 5'b10001;

  typedef enum logic [1:0] {IDLE, SAVE, LR, VEC} state_t;

  state_t state;

  logic [6:0]        win_p0;
  logic [4:0]        mode_p0;
  logic [DATA_W-1:0] lr_p0;
  logic [DATA_W-1:0] vec_p0;

  function automatic logic [6:0] pick_winner(
    input logic r, input logic da, input logic fq, input logic iq,
    input logic pa, input logic un, input logic sv,
    input logic f_mask, input logic i_mask);
    logic [6:0] w;
    w = '0;
    if (r)                  w[B_RESET] = 1'b1;
    else if (da)            w[B_DABT]  = 1'b1;
    else if (fq && !f_mask) w[B_FIQ]   = 1'b1;
    else if (iq && !i_mask) w[B_IRQ]   = 1'b1;
    else if (pa)            w[B_PABT]  = 1'b1;
    else if (un)            w[B_UNDEF] = 1'b1;
    else if (sv)            w[B_SVC]   = 1'b1;
    return w;
  endfunction

  function automatic logic [4:0] target_mode(input logic [6:0] w);
    logic [4:0] m;
    m = MODE_SVC;
    if (w[B_UNDEF])                m = MODE_UND;
    else if (w[B_PABT] | w[B_DABT]) m = MODE_ABT;
    else if (w[B_IRQ])             m = MODE_IRQ;
    else if (w[B_FIQ])             m = MODE_FIQ;
    return m;
  endfunction

  function automatic logic [7:0] vec_offset(input logic [6:0] w);
    logic [7:0] o;
    o = 8'h00;
    if (w[B_UNDEF])     o = 8'h04;
    else if (w[B_SVC])  o = 8'h08;
    else if (w[B_PABT]) o = 8'h0C;
    else if (w[B_DABT]) o = 8'h10;
    else if (w[B_IRQ])  o = 8'h18;
    else if (w[B_FIQ])  o = 8'h1C;
    return o;
  endfunction

  // Data aborts return two instructions past the faulting one; the rest return one.
  function automatic logic [DATA_W-1:0] lr_value(input logic [6:0] w,
                                                 input logic [DATA_W-1:0] pc);
    logic [DATA_W-1:0] inc;
    inc = w[B_DABT] ? DATA_W'(8) : DATA_W'(4);
    return pc + inc;
  endfunction

  function automatic logic [DATA_W-1:0] new_cpsr(input logic [6:0] w,
                                                 input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] n;
    n      = c;
    n[4:0] = target_mode(w);
    n[5]   = 1'b0;
    n[7]   = 1'b1;
    if (w[B_RESET] | w[B_FIQ]) n[6] = 1'b1;
    return n;
  endfunction

  logic [6:0]        win_c;
  logic              any_elig;
  logic              take;
  logic [DATA_W-1:0] vbase_c;

  assign win_c    = pick_winner(exc_reset, exc_dabt, fiq, irq, exc_pabt, exc_undef,
                                exc_svc, cpsr_in[6], cpsr_in[7]);
  assign any_elig = exc_dabt | exc_pabt | exc_undef | exc_svc |
                    (fiq & ~cpsr_in[6]) | (irq & ~cpsr_in[7]);
  // exc_reset restarts the sequence from any state; other requests only start from IDLE.
  assign take     = exc_reset | ((state == IDLE) & core_idle & any_elig);
  assign vbase_c  = hivecs ? HVBASE : VBASE;

  assign m_out = (state == IDLE) ? cpsr_in[4:0] : mode_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      write_reg <= 1'b0;
      write_pc  <= 1'b0;
      cpsr_we   <= 1'b0;
      spsr_we   <= 1'b0;
      exc_ack   <= '0;
      w_addr    <= '0;
      w_data    <= '0;
      pc_data   <= '0;
      cpsr_out  <= '0;
      spsr_data <= '0;
      spsr_mode <= '0;
      win_p0    <= '0;
      mode_p0   <= '0;
      lr_p0     <= '0;
      vec_p0    <= '0;
    end else begin
      done      <= 1'b0;
      write_reg <= 1'b0;
      write_pc  <= 1'b0;
      cpsr_we   <= 1'b0;
      spsr_we   <= 1'b0;
      exc_ack   <= '0;
      if (take) begin
        // Sampling edge: latch the entry context and present the SAVE cycle.
        state     <= SAVE;
        busy      <= 1'b1;
        win_p0    <= win_c;
        mode_p0   <= target_mode(win_c);
        lr_p0     <= lr_value(win_c, exc_pc);
        vec_p0    <= vbase_c | {{(DATA_W-8){1'b0}}, vec_offset(win_c)};
        cpsr_we   <= 1'b1;
        cpsr_out  <= new_cpsr(win_c, cpsr_in);
        spsr_we   <= ~win_c[B_RESET];
        spsr_data <= cpsr_in;
        spsr_mode <= target_mode(win_c);
      end else begin
        case (state)
          SAVE: begin
            if (win_p0[B_RESET]) begin
              state    <= VEC;
              write_pc <= 1'b1;
              pc_data  <= vec_p0;
              done     <= 1'b1;
              exc_ack  <= win_p0;
            end else begin
              state     <= LR;
              write_reg <= 1'b1;
              w_addr    <= 4'd14;
              w_data    <= lr_p0;
            end
          end
          LR: begin
            state    <= VEC;
            write_pc <= 1'b1;
            pc_data  <= vec_p0;
            done     <= 1'b1;
            exc_ack  <= win_p0;
          end
          VEC: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exception_entry.sv
// Directed bench for exception_entry: drives inputs on negedge, checks registered
// outputs at the following negedge against hand-computed values.
module tb_exception_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_reset, exc_undef, exc_svc, exc_pabt, exc_dabt, irq, fiq;
  logic        core_idle;
  logic [31:0] exc_pc;
  logic [31:0] cpsr_in;
  logic        hivecs;
  logic [4:0]  m_out;
  logic        write_reg;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        write_pc;
  logic [31:0] pc_data;
  logic        cpsr_we;
  logic [31:0] cpsr_out;
  logic        spsr_we;
  logic [31:0] spsr_data;
  logic [4:0]  spsr_mode;
  logic        busy;
  logic        done;
  logic [6:0]  exc_ack;

  int n_assert = 0;
  int n_fail   = 0;

  exception_entry dut (
    .clk(clk), .rst(rst),
    .exc_reset(exc_reset), .exc_undef(exc_undef), .exc_svc(exc_svc),
    .exc_pabt(exc_pabt), .exc_dabt(exc_dabt), .irq(irq), .fiq(fiq),
    .core_idle(core_idle), .exc_pc(exc_pc), .cpsr_in(cpsr_in), .hivecs(hivecs),
    .m_out(m_out), .write_reg(write_reg), .w_addr(w_addr), .w_data(w_data),
    .write_pc(write_pc), .pc_data(pc_data), .cpsr_we(cpsr_we), .cpsr_out(cpsr_out),
    .spsr_we(spsr_we), .spsr_data(spsr_data), .spsr_mode(spsr_mode),
    .busy(busy), .done(done), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {exc_reset, exc_undef, exc_svc, exc_pabt, exc_dabt, irq, fiq} = '0;
    core_idle = 1'b0;
    exc_pc    = 32'h0;
    cpsr_in   = 32'h10;
    hivecs    = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", {28'd0, write_reg, write_pc, cpsr_we, spsr_we}, 32'd0);
    chk("rst_ack", 32'(exc_ack), 32'd0);
    chk("rst_pc_data", pc_data, 32'd0);
    chk("rst_cpsr_out", cpsr_out, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_m_out", 32'(m_out), 32'h10);
    rst = 1'b0;
    step();

    // IRQ taken
    exc_pc = 32'h1000; irq = 1'b1; core_idle = 1'b1;
    step();
    chk("irq_save_busy", 32'(busy), 32'd1);
    chk("irq_save_we", {30'd0, cpsr_we, spsr_we}, 32'd3);
    chk("irq_save_spsr", spsr_data, 32'h10);
    chk("irq_save_spsr_mode", 32'(spsr_mode), 32'h12);
    chk("irq_save_cpsr_out", cpsr_out, 32'h92);
    chk("irq_save_m_out", 32'(m_out), 32'h12);
    chk("irq_save_wr", 32'(write_reg), 32'd0);
    step();
    chk("irq_lr_wr", 32'(write_reg), 32'd1);
    chk("irq_lr_addr", 32'(w_addr), 32'd14);
    chk("irq_lr_data", w_data, 32'h1004);
    chk("irq_lr_m_out", 32'(m_out), 32'h12);
    chk("irq_lr_cpsr_we", 32'(cpsr_we), 32'd0);
    step();
    chk("irq_vec_wpc", 32'(write_pc), 32'd1);
    chk("irq_vec_pc", pc_data, 32'h18);
    chk("irq_vec_done", 32'(done), 32'd1);
    chk("irq_vec_ack", 32'(exc_ack), 32'b0100000);
    irq = 1'b0;
    step();
    chk("irq_idle_busy", 32'(busy), 32'd0);
    chk("irq_idle_done", 32'(done), 32'd0);
    chk("irq_idle_ack", 32'(exc_ack), 32'd0);

    // Simultaneous fiq + irq: FIQ wins
    fiq = 1'b1; irq = 1'b1;
    step();
    chk("fiq_save_cpsr_out", cpsr_out, 32'hD1);
    chk("fiq_save_spsr_mode", 32'(spsr_mode), 32'h11);
    step();
    chk("fiq_lr_m_out", 32'(m_out), 32'h11);
    step();
    chk("fiq_vec_pc", pc_data, 32'h1C);
    chk("fiq_vec_ack", 32'(exc_ack), 32'b1000000);
    fiq = 1'b0; cpsr_in = 32'hD1;
    repeat (5) begin
      step();
      chk("fiq_then_irq_masked", 32'(busy), 32'd0);
    end
    irq = 1'b0; cpsr_in = 32'h10;

    // IRQ masked by I bit
    cpsr_in = 32'h90; irq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("irq_masked_busy", 32'(busy), 32'd0);
    end
    chk("irq_masked_m_out", 32'(m_out), 32'h10);

    // IRQ held off by core_idle
    cpsr_in = 32'h10; core_idle = 1'b0;
    repeat (5) begin
      step();
      chk("irq_not_idle_busy", 32'(busy), 32'd0);
    end
    core_idle = 1'b1;
    step();
    chk("irq_idle_go_busy", 32'(busy), 32'd1);
    chk("irq_idle_go_mode", 32'(spsr_mode), 32'h12);
    step();
    step();
    chk("irq_idle_go_done", 32'(done), 32'd1);
    irq = 1'b0;
    step();

    // DABT with high vectors
    exc_pc = 32'h2000; hivecs = 1'b1; exc_dabt = 1'b1;
    step();
    chk("dabt_save_cpsr_out", cpsr_out, 32'h97);
    chk("dabt_save_m_out", 32'(m_out), 32'h17);
    step();
    chk("dabt_lr_data", w_data, 32'h2008);
    chk("dabt_lr_m_out", 32'(m_out), 32'h17);
    step();
    chk("dabt_vec_pc", pc_data, 32'hFFFF0010);
    chk("dabt_vec_ack", 32'(exc_ack), 32'b0010000);
    exc_dabt = 1'b0; hivecs = 1'b0;
    step();

    // UNDEF with LR wrap, held through VEC to show the mandatory IDLE gap
    exc_pc = 32'hFFFF_FFFC; exc_undef = 1'b1;
    step();
    chk("und_save_spsr_mode", 32'(spsr_mode), 32'h1B);
    step();
    chk("und_lr_wrap", w_data, 32'h0);
    step();
    chk("und_vec_pc", pc_data, 32'h04);
    chk("und_vec_ack", 32'(exc_ack), 32'b0000010);
    step();
    chk("und_gap_busy", 32'(busy), 32'd0);
    step();
    chk("und_reenter_busy", 32'(busy), 32'd1);
    step();
    step();
    exc_undef = 1'b0;
    step();

    // Reset exception during the LR cycle of an SVC entry
    exc_pc = 32'h3000; exc_svc = 1'b1;
    step();
    chk("svc_save_mode", 32'(spsr_mode), 32'h13);
    step();
    chk("svc_lr_data", w_data, 32'h3004);
    exc_reset = 1'b1; exc_svc = 1'b0;
    step();
    chk("rstx_save_wpc", 32'(write_pc), 32'd0);
    chk("rstx_save_busy", 32'(busy), 32'd1);
    chk("rstx_save_we", {30'd0, cpsr_we, spsr_we}, 32'd2);
    chk("rstx_save_cpsr_out", cpsr_out, 32'hD3);
    chk("rstx_save_m_out", 32'(m_out), 32'h13);
    exc_reset = 1'b0;
    step();
    chk("rstx_vec_wpc", 32'(write_pc), 32'd1);
    chk("rstx_vec_pc", pc_data, 32'h0);
    chk("rstx_vec_done", 32'(done), 32'd1);
    chk("rstx_vec_wr", 32'(write_reg), 32'd0);
    chk("rstx_vec_ack", 32'(exc_ack), 32'b0000001);
    step();
    chk("rstx_idle_busy", 32'(busy), 32'd0);

    // rst asserted during SAVE of an IRQ entry
    irq = 1'b1;
    step();
    chk("rstsave_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rstsave_after_busy", 32'(busy), 32'd0);
    chk("rstsave_after_strobes", {28'd0, write_reg, write_pc, cpsr_we, spsr_we}, 32'd0);
    chk("rstsave_after_done", 32'(done), 32'd0);
    step();
    chk("rstsave_held_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("rstsave_reenter_busy", 32'(busy), 32'd1);
    chk("rstsave_reenter_cpsr", cpsr_out, 32'h92);
    step();
    step();
    chk("rstsave_reenter_pc", pc_data, 32'h18);
    irq = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_entry.md
# exception_entry

Exception-entry sequencer for the ARM-style core. It arbitrates pending exception requests and selects the winning one. It then drives the banked register file through a fixed multi-cycle sequence on the file's ports: mode select M, the r14 write port and the PC write port. The sequence saves CPSR to the target SPSR, switches mode, writes the banked LR, and loads the vector into PC. It sits between the core control unit and the register file, on the write side of the banking logic.

## Interface
- VBASE, 32'h0000_0000, low vector base used when hivecs=0
- HVBASE, 32'hFFFF_0000, high vector base used when hivecs=1
- clk  in  1  clock; all state updates on posedge (register file writes on the following negedge)
- rst  in  1  reset rst, synchronous, active-high
- exc_reset, exc_undef, exc_svc, exc_pabt, exc_dabt, irq, fiq  in  1 each  level request lines
- core_idle  in  1  core is at an instruction boundary; required to start any entry except reset
- exc_pc  in  32  address of the current instruction, used as the LR base
- cpsr_in  in  32  current CPSR (mode [4:0], T [5], F [6], I [7])
- hivecs  in  1  selects HVBASE
- m_out  out  5  mode to the register file M input
- write_reg  out  1, w_addr  out  4, w_data  out  32  register file write port
- write_pc  out  1, pc_data  out  32  register file PC port
- cpsr_we  out  1, cpsr_out  out  32  new CPSR
- spsr_we  out  1, spsr_data  out  32, spsr_mode  out  5  SPSR save for the target mode
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse in the final cycle
- exc_ack  out  7  one-hot {fiq,irq,dabt,pabt,svc,undef,reset}, valid only while done=1

## Operation
- Priority, highest first: reset > dabt > fiq > irq > pabt > undef > svc.
- irq is eligible only if cpsr_in[7]=0; fiq is eligible only if cpsr_in[6]=0.
- Target mode and vector offset per exception:
  - reset: SVC 10011, offset 0x00
  - undef: UND 11011, offset 0x04
  - svc: SVC 10011, offset 0x08
  - pabt: ABT 10111, offset 0x0C
  - dabt: ABT 10111, offset 0x10
  - irq: IRQ 10010, offset 0x18
  - fiq: FIQ 10001, offset 0x1C
- LR value is exc_pc + 4 for undef, svc, pabt, irq and fiq, and exc_pc + 8 for dabt. Addition is 32-bit and wraps modulo 2^32. pc_data = base | offset.
- new CPSR = cpsr_in with:
  - [4:0] set to the target mode
  - [7] set
  - [5] cleared
  - [6] set for reset and fiq, unchanged otherwise
- States: IDLE, SAVE, LR, VEC.
  - IDLE: a selection is made at a posedge when (core_idle=1 and any eligible request is present) or exc_reset=1. The FSM then goes to SAVE. The block latches the winning exception, cpsr_in and exc_pc at that edge.
  - SAVE: cpsr_we=1 with cpsr_out = new CPSR. spsr_we=1 with spsr_data = latched CPSR and spsr_mode = target mode; spsr_we=0 for reset. m_out = target mode. Next state is LR, or VEC for reset.
  - LR: write_reg=1, w_addr=14, w_data = LR value, m_out = target mode. Next state is VEC.
  - VEC: write_pc=1, pc_data = vector, done=1, exc_ack = winner, m_out = target mode. Next state is IDLE.
- In IDLE, m_out = cpsr_in[4:0] (combinational pass-through). All strobes are 0.
- Requests other than exc_reset are ignored while busy. They are not queued; a level still present is re-arbitrated in IDLE.
- exc_reset=1 while busy (any state) aborts the sequence: no further strobes belonging to the old entry are issued. The next state is SAVE with reset selected, using the cpsr_in and exc_pc sampled at that edge.
- Request lines are levels. The source deasserts on exc_ack; the block does not clear them.

## Timing
- Reset values (rst=1 at posedge): state IDLE.
  - busy, done, write_reg, write_pc, cpsr_we, spsr_we = 0
  - exc_ack = 0; w_addr, w_data, pc_data, cpsr_out, spsr_data, spsr_mode = 0
  - m_out = cpsr_in[4:0]
- rst has priority over every request, including exc_reset.
- All outputs are registered except m_out in IDLE.
- Strobes are stable for the whole cycle, so the register file's negedge write sees the new m_out.
- Latency from the sampling edge:
  - SAVE in cycle +1, LR in cycle +2, VEC/done in cycle +3: 3 busy cycles.
  - Reset exception: SAVE in cycle +1, VEC in cycle +2.
- busy = 1 in SAVE, LR and VEC.
- A new entry can be sampled at the edge ending the VEC cycle+1, i.e. the first IDLE cycle. There are no back-to-back entries without one IDLE cycle.

## Test plan
- IRQ taken: cpsr_in=0x10, exc_pc=0x1000, irq=1, core_idle=1.
  - SAVE: spsr_data=0x10, spsr_mode=10010, cpsr_out=0x92.
  - LR: w_addr=14, w_data=0x1004, m_out=10010.
  - VEC: pc_data=0x18, exc_ack=0100000.
- Simultaneous fiq+irq with cpsr_in=0x10: FIQ wins, cpsr_out=0xD1, pc_data=0x1C. IRQ is then masked by the new F/I bits held by the core.
- IRQ masked and gating:
  - cpsr_in=0x90, irq=1 -> busy stays 0 for 20 cycles.
  - irq with core_idle=0 -> no entry until core_idle=1.
- DABT with exc_pc=0x2000 and hivecs=1: w_data=0x2008, m_out=10111, cpsr_out=0x97, pc_data=0xFFFF0010.
- Reset mid-entry: assert exc_reset during the LR state of an SVC entry.
  - No write_pc to 0x08 occurs.
  - Next cycle is SAVE with spsr_we=0 and cpsr_out=0xD3.
  - Following cycle: pc_data=0x00, done=1, no write_reg.
- rst asserted during SAVE: next cycle all strobes are 0 and busy=0; a pending irq re-enters only after rst is released.
